// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: the NOP encoding, IF/ID control state encodings
// and default widths for the hazard/stall control blocks.
package cpu_pipe_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int CNT_W_DEF     = 16;
    localparam int MAX_STALL_DEF = 8;

    // sll $0,$0,0 -- all-zero word, decodes to no register writes and no memory access
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } if_id_state_t;

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive and total stall cycles (saturating) and latches a sticky
// timeout once a single stall run reaches MAX_STALL cycles.
module stall_watchdog #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    output logic [CNT_W-1:0] stall_run,
    output logic [CNT_W-1:0] stall_total,
    output logic             stall_timeout
);

    logic [CNT_W-1:0] run_next;
    logic [CNT_W-1:0] total_next;

    // Counters stick at all-ones instead of wrapping back to a misleading small value
    always_comb begin
        run_next   = '0;
        total_next = stall_total;
        if (stall_i) begin
            run_next   = (stall_run == '1) ? stall_run : stall_run + CNT_W'(1);
            total_next = (stall_total == '1) ? stall_total : stall_total + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_run     <= '0;
            stall_total   <= '0;
            stall_timeout <= 1'b0;
        end else begin
            stall_run   <= run_next;
            stall_total <= total_next;
            if (stall_i && (run_next == CNT_W'(MAX_STALL)))
                stall_timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID pipeline register and PC write gate: holds fetch on a load-use stall,
// squashes the fetched instruction to NOP on a taken branch/jump.
module if_id_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MAX_STALL = MAX_STALL_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] if_pc_plus4,
    input  logic [DATA_W-1:0] if_instr,
    output logic              pc_write_en,
    output logic [DATA_W-1:0] id_pc_plus4,
    output logic [DATA_W-1:0] id_instr,
    output logic              id_valid,
    output logic              ex_bubble,
    output logic [CNT_W-1:0]  stall_run,
    output logic [CNT_W-1:0]  stall_total,
    output logic              stall_timeout
);

    if_id_state_t state;
    if_id_state_t state_next;

    assign pc_write_en = ~stall_i;
    assign ex_bubble   = stall_i;

    // A stalled branch has stale operands, so stall always wins over flush
    always_comb begin
        state_next = state;
        case (state)
            RUN, HOLD, SQUASH: begin
                if (stall_i)      state_next = HOLD;
                else if (flush_i) state_next = SQUASH;
                else              state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_instr    <= DATA_W'(NOP_INSTR);
            id_pc_plus4 <= '0;
            id_valid    <= 1'b0;
        end else if (!stall_i) begin
            id_pc_plus4 <= if_pc_plus4;
            if (flush_i) begin
                id_instr <= DATA_W'(NOP_INSTR);
                id_valid <= 1'b0;
            end else begin
                id_instr <= if_instr;
                id_valid <= 1'b1;
            end
        end
    end

    stall_watchdog #(
        .CNT_W     (CNT_W),
        .MAX_STALL (MAX_STALL)
    ) u_watchdog (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .stall_run     (stall_run),
        .stall_total   (stall_total),
        .stall_timeout (stall_timeout)
    );

endmodule
